// File: rtl/systolic_array_nxn_pkg.sv
// Shared definitions for the NxN systolic matrix multiplier.
// Holds the 2-bit FSM state encoding, default operand/accumulator widths
// and the flush-length helper used to size the post-job pipeline drain.
package systolic_array_nxn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int DW_DEF = 16;
    localparam int OW_DEF = 32;

    // Cycles needed after the last beat for it to reach PE(N-1,N-1)
    // and for the accumulator to settle.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_array_nxn_if.sv
// Job bus of the systolic array: operand beats in, result rows out.
// Ports: in_valid/in_ready/in_last + a_vec/b_vec (one column of A, one row of B per beat),
//        out_valid/out_ready/out_last + out_row (one row of C per beat), busy status.
interface systolic_array_nxn_if
    import systolic_array_nxn_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [N*DW-1:0] a_vec;
    logic [N*DW-1:0] b_vec;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [N*OW-1:0] out_row;
    logic            busy;

    // Producer/consumer side
    modport master (
        output in_valid, in_last, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, out_row, out_last, busy
    );

    // Array side
    modport slave (
        input  in_valid, in_last, a_vec, b_vec, out_ready,
        output in_ready, out_valid, out_row, out_last, busy
    );
endinterface

// File: rtl/systolic_array_nxn_mac_pe.sv
// Processing element: signed DW x DW multiply-accumulate into an OW-bit wrapping accumulator.
// Latency: operands forwarded east/south one cycle later; accumulator updates every cycle.
// Backpressure: none; clr_i zeroes the accumulator at the next edge.
// Ports: clk, reset (sync, active-high), clr_i, a_i/b_i operands in, a_o/b_o forwarded operands, acc_o.
module mac_pe
    import systolic_array_nxn_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [DW-1:0] a_o,
    output logic signed [DW-1:0] b_o,
    output logic signed [OW-1:0] acc_o
);
    logic signed [DW-1:0]   a_q;
    logic signed [DW-1:0]   b_q;
    logic signed [OW-1:0]   acc_q;
    logic signed [OW-1:0]   acc_d;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        prod  = (2*DW)'(a_i) * (2*DW)'(b_i);
        // Sign-extend the full product, then wrap modulo 2^OW.
        acc_d = acc_q + OW'(prod);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= clr_i ? '0 : acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/systolic_array_nxn.sv
// Output-stationary NxN systolic array computing C = A x B over K accepted beats.
// Latency: first result row valid 2N cycles after the in_last beat is accepted.
// Backpressure: in_ready low during FLUSH/DRAIN; result rows held stable until out_ready.
// Ports: clk, reset (sync, active-high), bus (slave side of systolic_array_nxn_if).
module systolic_array_nxn
    import systolic_array_nxn_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
)
(
    input  logic                 clk,
    input  logic                 reset,
    systolic_array_nxn_if.slave  bus
);
    localparam int            CW         = $clog2(2 * N);
    localparam int            RW         = $clog2(N);
    localparam logic [CW-1:0] FLUSH_INIT = CW'(flush_len(N) - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   flush_q, flush_d;
    logic [RW-1:0]   row_q, row_d;
    logic            out_valid_q, out_valid_d;
    logic [N*OW-1:0] out_row_q, out_row_d;
    logic [RW-1:0]   load_idx;
    logic            load_row;
    logic            clr;
    logic            in_ready;
    logic            accept;

    // a_h[i][j] / b_h[i][j]: operands entering PE(i,j)
    logic signed [DW-1:0] a_h   [N][N];
    logic signed [DW-1:0] b_h   [N][N];
    logic signed [OW-1:0] acc_h [N][N];

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_FEED);
    assign accept   = bus.in_valid && in_ready;

    // Skew lines: lane i enters the grid i cycles late so that A[i][k] and
    // B[k][j] meet in PE(i,j) in the same cycle. Idle cycles feed zeros.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic signed [DW-1:0] a_in;
        logic signed [DW-1:0] b_in;

        assign a_in = accept ? bus.a_vec[i*DW +: DW] : '0;
        assign b_in = accept ? bus.b_vec[i*DW +: DW] : '0;

        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_in;
            assign b_h[0][0] = b_in;
        end else begin : g_dly
            logic signed [DW-1:0] a_dly_q [i];
            logic signed [DW-1:0] b_dly_q [i];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int d = 0; d < i; d++) begin
                        a_dly_q[d] <= '0;
                        b_dly_q[d] <= '0;
                    end
                end else begin
                    a_dly_q[0] <= a_in;
                    b_dly_q[0] <= b_in;
                    for (int d = 1; d < i; d++) begin
                        a_dly_q[d] <= a_dly_q[d-1];
                        b_dly_q[d] <= b_dly_q[d-1];
                    end
                end
            end

            assign a_h[i][0] = a_dly_q[i-1];
            assign b_h[0][i] = b_dly_q[i-1];
        end
    end

    // PE grid: A flows east, B flows south.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DW-1:0] a_east;
            logic signed [DW-1:0] b_south;

            mac_pe #(.DW(DW), .OW(OW)) u_pe (
                .clk   (clk),
                .reset (reset),
                .clr_i (clr),
                .a_i   (a_h[i][j]),
                .b_i   (b_h[i][j]),
                .a_o   (a_east),
                .b_o   (b_south),
                .acc_o (acc_h[i][j])
            );

            if (j < N - 1) begin : g_east
                assign a_h[i][j+1] = a_east;
            end else begin : g_east_edge
                // Eastern edge: forwarded A has no consumer.
                logic signed [DW-1:0] a_east_unused;
                assign a_east_unused = a_east;
            end

            if (i < N - 1) begin : g_south
                assign b_h[i+1][j] = b_south;
            end else begin : g_south_edge
                // Southern edge: forwarded B has no consumer.
                logic signed [DW-1:0] b_south_unused;
                assign b_south_unused = b_south;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        load_row    = 1'b0;
        load_idx    = row_q;
        clr         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.in_last) begin
                        state_d = ST_FLUSH;
                        flush_d = FLUSH_INIT;
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                if (accept && bus.in_last) begin
                    state_d = ST_FLUSH;
                    flush_d = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                // On the final flush cycle every accumulator is settled, so
                // row 0 can be captured and presented on the next cycle.
                if (flush_q == '0) begin
                    state_d     = ST_DRAIN;
                    out_valid_d = 1'b1;
                    row_d       = '0;
                    load_row    = 1'b1;
                    load_idx    = '0;
                end else begin
                    flush_d = flush_q - CW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        row_d       = '0;
                        clr         = 1'b1;
                    end else begin
                        row_d    = row_q + RW'(1);
                        load_row = 1'b1;
                        load_idx = row_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered row mux
        if (load_row) begin
            for (int j = 0; j < N; j++) begin
                out_row_d[j*OW +: OW] = acc_h[load_idx][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flush_q     <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_last  = out_valid_q && (row_q == ROW_LAST);
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Self-checking bench for systolic_array_nxn with an N=2 and an N=4 instance.
// A shared driver is steered to one instance by sel; results are compared against
// a plain matrix-product model (32-bit wrapping) computed in the bench.
module tb_systolic_array_nxn;
    logic clk;
    logic reset;
    logic sel;              // 0: N=2 instance, 1: N=4 instance
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    logic        in_valid_drv;
    logic        in_last_drv;
    logic        out_ready_drv;
    logic [15:0] a_drv [4];
    logic [15:0] b_drv [4];

    int A_m [4][8];
    int B_m [8][4];
    int C_m [4][4];

    logic        obs_valid;
    logic        obs_in_ready;
    logic        obs_last;
    logic        obs_busy;
    logic [31:0] obs_lane [4];

    systolic_array_nxn_if #(.N(2), .DW(16), .OW(32)) if2 ();
    systolic_array_nxn_if #(.N(4), .DW(16), .OW(32)) if4 ();

    systolic_array_nxn #(.N(2), .DW(16), .OW(32)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));
    systolic_array_nxn #(.N(4), .DW(16), .OW(32)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));

    assign if2.in_valid  = in_valid_drv & ~sel;
    assign if2.in_last   = in_last_drv;
    assign if2.a_vec     = {a_drv[1], a_drv[0]};
    assign if2.b_vec     = {b_drv[1], b_drv[0]};
    assign if2.out_ready = out_ready_drv & ~sel;

    assign if4.in_valid  = in_valid_drv & sel;
    assign if4.in_last   = in_last_drv;
    assign if4.a_vec     = {a_drv[3], a_drv[2], a_drv[1], a_drv[0]};
    assign if4.b_vec     = {b_drv[3], b_drv[2], b_drv[1], b_drv[0]};
    assign if4.out_ready = out_ready_drv & sel;

    always_comb begin
        if (sel) begin
            obs_valid    = if4.out_valid;
            obs_in_ready = if4.in_ready;
            obs_last     = if4.out_last;
            obs_busy     = if4.busy;
            obs_lane[0]  = if4.out_row[31:0];
            obs_lane[1]  = if4.out_row[63:32];
            obs_lane[2]  = if4.out_row[95:64];
            obs_lane[3]  = if4.out_row[127:96];
        end else begin
            obs_valid    = if2.out_valid;
            obs_in_ready = if2.in_ready;
            obs_last     = if2.out_last;
            obs_busy     = if2.busy;
            obs_lane[0]  = if2.out_row[31:0];
            obs_lane[1]  = if2.out_row[63:32];
            obs_lane[2]  = 32'd0;
            obs_lane[3]  = 32'd0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Switch the observed/driven instance and realign to posedge+1.
    task automatic pick(input logic s);
        sel = s;
        @(posedge clk); #1;
    endtask

    task automatic compute(input int n, input int k);
        int s;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += A_m[i][kk] * B_m[kk][j];
                C_m[i][j] = s;
            end
        end
    endtask

    task automatic rand_job(input int n, input int k);
        for (int i = 0; i < n; i++)
            for (int kk = 0; kk < k; kk++) begin
                A_m[i][kk] = int'($urandom_range(0, 65535)) - 32768;
                B_m[kk][i] = int'($urandom_range(0, 65535)) - 32768;
            end
    endtask

    task automatic fill_const(input int n, input int k, input int v);
        for (int i = 0; i < n; i++)
            for (int kk = 0; kk < k; kk++) begin
                A_m[i][kk] = v;
                B_m[kk][i] = v;
            end
    endtask

    // gap_mode: 0 back-to-back, 1 two bubbles between beats, 2 random 0..2 bubbles.
    // Bubbles carry junk data with in_last=1 that must be ignored.
    task automatic feed_beats(input int n, input int k, input int gap_mode, output int c_last);
        int gap;
        c_last = 0;
        for (int kk = 0; kk < k; kk++) begin
            gap = 0;
            if (kk > 0 && gap_mode == 1) gap = 2;
            if (kk > 0 && gap_mode == 2) gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                in_valid_drv = 1'b0;
                in_last_drv  = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    a_drv[i] = 16'($urandom);
                    b_drv[i] = 16'($urandom);
                end
                @(posedge clk); #1;
            end
            in_valid_drv = 1'b1;
            in_last_drv  = (kk == k - 1);
            for (int i = 0; i < 4; i++) begin
                a_drv[i] = (i < n) ? 16'(A_m[i][kk]) : 16'($urandom);
                b_drv[i] = (i < n) ? 16'(B_m[kk][i]) : 16'($urandom);
            end
            chk($sformatf("in_ready_beat%0d", kk), 32'(obs_in_ready), 32'd1);
            c_last = cyc;
            @(posedge clk); #1;
        end
        in_valid_drv = 1'b0;
        in_last_drv  = 1'b0;
        chk("in_ready_flush", 32'(obs_in_ready), 32'd0);
        chk("busy_flush", 32'(obs_busy), 32'd1);
    endtask

    // stall_mode: 0 none, >0 stall row 0 for that many cycles, <0 random stalls per row.
    task automatic drain_check(input int n, input int c_last, input int stall_mode, input string tag);
        int waited;
        int stalls;
        waited = 0;
        while (!obs_valid && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({tag, "_valid_rise"}, 32'(obs_valid), 32'd1);
        chk({tag, "_latency"}, cyc - c_last, 2 * n);
        for (int r = 0; r < n; r++) begin
            for (int j = 0; j < n; j++)
                chk($sformatf("%s_r%0d_c%0d", tag, r, j), obs_lane[j], C_m[r][j]);
            chk($sformatf("%s_last_r%0d", tag, r), 32'(obs_last), (r == n - 1) ? 32'd1 : 32'd0);
            stalls = 0;
            if (stall_mode < 0) stalls = int'($urandom_range(0, 2));
            else if (r == 0)    stalls = stall_mode;
            for (int s = 0; s < stalls; s++) begin
                @(posedge clk); #1;
                chk($sformatf("%s_stall_valid_r%0d", tag, r), 32'(obs_valid), 32'd1);
                chk($sformatf("%s_stall_inrdy_r%0d", tag, r), 32'(obs_in_ready), 32'd0);
                for (int j = 0; j < n; j++)
                    chk($sformatf("%s_stall_r%0d_c%0d", tag, r, j), obs_lane[j], C_m[r][j]);
            end
            out_ready_drv = 1'b1;
            @(posedge clk); #1;
            out_ready_drv = 1'b0;
        end
        chk({tag, "_done_valid"}, 32'(obs_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(obs_busy), 32'd0);
        chk({tag, "_done_inrdy"}, 32'(obs_in_ready), 32'd1);
    endtask

    initial begin
        int c;
        int n;
        int k;

        sel           = 1'b0;
        reset         = 1'b1;
        in_valid_drv  = 1'b0;
        in_last_drv   = 1'b0;
        out_ready_drv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_drv[i] = 16'd0;
            b_drv[i] = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset state of both instances
        pick(1'b0);
        chk("rst2_valid", 32'(obs_valid), 32'd0);
        chk("rst2_last", 32'(obs_last), 32'd0);
        chk("rst2_busy", 32'(obs_busy), 32'd0);
        chk("rst2_row0", obs_lane[0], 32'd0);
        chk("rst2_row1", obs_lane[1], 32'd0);
        pick(1'b1);
        chk("rst4_valid", 32'(obs_valid), 32'd0);
        chk("rst4_busy", 32'(obs_busy), 32'd0);
        for (int j = 0; j < 4; j++) chk($sformatf("rst4_row%0d", j), obs_lane[j], 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst4_inrdy", 32'(obs_in_ready), 32'd1);
        pick(1'b0);
        chk("rst2_inrdy", 32'(obs_in_ready), 32'd1);

        // N=2 reference product
        A_m[0][0] = 1; A_m[0][1] = 2; A_m[1][0] = 3; A_m[1][1] = 4;
        B_m[0][0] = 5; B_m[0][1] = 6; B_m[1][0] = 7; B_m[1][1] = 8;
        compute(2, 2);
        feed_beats(2, 2, 0, c);
        drain_check(2, c, 0, "n2_basic");

        // Same job, consumer stalls row 0 for 5 cycles
        feed_beats(2, 2, 0, c);
        drain_check(2, c, 5, "n2_stall");

        // N=4 identity x B
        pick(1'b1);
        for (int i = 0; i < 4; i++)
            for (int kk = 0; kk < 4; kk++) begin
                A_m[i][kk] = (i == kk) ? 1 : 0;
                B_m[kk][i] = 4 * kk + i + 1;
            end
        compute(4, 4);
        feed_beats(4, 4, 0, c);
        drain_check(4, c, 0, "n4_ident");

        // Random operands: back-to-back and with 1,0,0,1 valid pattern
        rand_job(4, 4);
        compute(4, 4);
        feed_beats(4, 4, 0, c);
        drain_check(4, c, 0, "n4_nobub");
        feed_beats(4, 4, 1, c);
        drain_check(4, c, 0, "n4_bubble");

        // Wrap and single-beat jobs
        fill_const(4, 4, -32768);
        compute(4, 4);
        feed_beats(4, 4, 0, c);
        drain_check(4, c, 0, "n4_wrap");
        fill_const(4, 1, -1);
        compute(4, 1);
        feed_beats(4, 1, 0, c);
        drain_check(4, c, 0, "n4_k1");

        // Randomised jobs on both sizes
        for (int t = 0; t < 6; t++) begin
            n = (t % 2 == 1) ? 4 : 2;
            k = int'($urandom_range(1, 6));
            pick(n == 4);
            rand_job(n, k);
            compute(n, k);
            feed_beats(n, k, 2, c);
            drain_check(n, c, -1, $sformatf("rnd%0d", t));
        end

        // Reset pulse mid-FLUSH aborts the job
        pick(1'b0);
        rand_job(2, 3);
        feed_beats(2, 3, 0, c);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(obs_busy), 32'd0);
        chk("abort_valid", 32'(obs_valid), 32'd0);
        chk("abort_inrdy", 32'(obs_in_ready), 32'd1);
        for (int w = 0; w < 8; w++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_quiet%0d", w), 32'(obs_valid), 32'd0);
        end
        rand_job(2, 2);
        compute(2, 2);
        feed_beats(2, 2, 0, c);
        drain_check(2, c, 0, "fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
